// File: rtl/nonogram_pkg.sv
// Shared definitions for the nonogram solver datapath: board geometry,
// framing constants, state/item encodings and small dimension helpers.
package nonogram_pkg;

    localparam int MAX_N   = 11;
    localparam int DIM_W   = 4;
    localparam int BOARD_W = MAX_N * MAX_N;

    localparam logic [7:0]       HDR_BYTE = 8'hA5;
    localparam logic [DIM_W-1:0] MAX_DIM  = DIM_W'(MAX_N);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} pkt_state_t;
    typedef enum logic [1:0] {HDR, DIMS, ROW, CHK} pkt_item_t;

    // Number of bytes needed to carry one row of 'cols' cells, i.e. ceil(cols/8).
    function automatic logic [DIM_W-1:0] bytesPerRow(input logic [DIM_W-1:0] cols);
        logic [DIM_W:0] sum;
        sum = {1'b0, cols} + {{(DIM_W-2){1'b0}}, 3'd7};
        return {2'b00, sum[DIM_W:3]};
    endfunction

    // A board is only framed when both dimensions are between 1 and MAX_N.
    function automatic logic dimsLegal(input logic [DIM_W-1:0] cols,
                                       input logic [DIM_W-1:0] rows);
        return (cols != '0) && (rows != '0) && (cols <= MAX_DIM) && (rows <= MAX_DIM);
    endfunction

endpackage

// File: rtl/row_byte_select.sv
// Picks byte k of row r out of the latched board. Column 0 lands in bit 0;
// any column at or beyond the board width reads as zero so partial bytes
// are padded cleanly.
module row_byte_select
    import nonogram_pkg::*;
(
    input  logic [BOARD_W-1:0] i_board,
    input  logic [DIM_W-1:0]   i_row,
    input  logic [DIM_W-1:0]   i_byteIdx,
    input  logic [DIM_W-1:0]   i_cols,
    output logic [7:0]         o_rowByte
);

    int w_col;
    int w_bitIdx;

    // Gather eight consecutive cells of the selected row, masking past the width.
    always_comb begin
        o_rowByte = '0;
        w_col     = 0;
        w_bitIdx  = 0;
        for (int j = 0; j < 8; j++) begin
            w_col    = int'(i_byteIdx) * 8 + j;
            w_bitIdx = int'(i_row) * MAX_N + w_col;
            if ((w_col < int'(i_cols)) && (w_col < MAX_N) && (w_bitIdx < BOARD_W)) begin
                o_rowByte[j] = i_board[w_bitIdx];
            end
        end
    end

endmodule

// File: rtl/solution_packetizer.sv
// Frames a solved board for the UART transmitter: header, packed dimensions,
// the board rows (ceil(n/8) bytes each) and a running XOR checksum. One byte
// is offered per transmitter handshake; requests arriving mid-frame are
// dropped and flagged through the sticky overrun bit.
module solution_packetizer
    import nonogram_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [BOARD_W-1:0] solution,
    input  logic [DIM_W-1:0]   n,
    input  logic [DIM_W-1:0]   m,
    input  logic               tx_ready,
    input  logic               tx_done,
    output logic [7:0]         byte_out,
    output logic               byte_valid,
    output logic               busy,
    output logic               frame_done,
    output logic               dim_err,
    output logic               overrun
);

    pkt_state_t         r_state;
    pkt_item_t          r_item;
    logic [BOARD_W-1:0] r_board;
    logic [DIM_W-1:0]   r_cols;
    logic [DIM_W-1:0]   r_rows;
    logic [DIM_W-1:0]   r_rowIdx;
    logic [DIM_W-1:0]   r_byteIdx;
    logic [7:0]         r_checksum;
    logic [7:0]         r_byteOut;
    logic               r_byteValid;
    logic               r_busy;
    logic               r_frameDone;
    logic               r_dimErr;
    logic               r_overrun;

    logic [7:0]         w_rowByte;
    logic [7:0]         w_curByte;
    logic [DIM_W-1:0]   w_bytesPerRow;
    logic               w_accept;
    logic               w_lastRowByte;
    logic               w_lastRow;

    row_byte_select u_rowSelect (
        .i_board   (r_board),
        .i_row     (r_rowIdx),
        .i_byteIdx (r_byteIdx),
        .i_cols    (r_cols),
        .o_rowByte (w_rowByte)
    );

    // The cycle that shows frame_done still belongs to the finishing frame,
    // so a request landing there is treated like any mid-frame request.
    assign w_accept      = (r_state == IDLE) && !r_frameDone;
    assign w_bytesPerRow = bytesPerRow(r_cols);
    assign w_lastRowByte = (r_byteIdx == w_bytesPerRow - DIM_W'(1));
    assign w_lastRow     = (r_rowIdx == r_rows - DIM_W'(1));

    assign byte_out   = r_byteOut;
    assign byte_valid = r_byteValid;
    assign busy       = r_busy;
    assign frame_done = r_frameDone;
    assign dim_err    = r_dimErr;
    assign overrun    = r_overrun;

    // Byte belonging to the item currently being offered to the transmitter.
    always_comb begin
        w_curByte = HDR_BYTE;
        unique case (r_item)
            HDR:  w_curByte = HDR_BYTE;
            DIMS: w_curByte = {r_rows, r_cols};
            ROW:  w_curByte = w_rowByte;
            CHK:  w_curByte = r_checksum;
        endcase
    end

    // Frame sequencer: capture, offer a byte, wait for its completion, advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_item      <= HDR;
            r_board     <= '0;
            r_cols      <= '0;
            r_rows      <= '0;
            r_rowIdx    <= '0;
            r_byteIdx   <= '0;
            r_checksum  <= '0;
            r_byteOut   <= '0;
            r_byteValid <= 1'b0;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
            r_dimErr    <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_byteValid <= 1'b0;
            r_frameDone <= 1'b0;
            r_dimErr    <= 1'b0;

            if (valid_in && !w_accept) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (valid_in && w_accept) begin
                        if (dimsLegal(n, m)) begin
                            r_board    <= solution;
                            r_cols     <= n;
                            r_rows     <= m;
                            r_rowIdx   <= '0;
                            r_byteIdx  <= '0;
                            r_checksum <= '0;
                            r_item     <= HDR;
                            r_busy     <= 1'b1;
                            r_state    <= SEND;
                        end else begin
                            r_dimErr <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (tx_ready) begin
                        r_byteOut   <= w_curByte;
                        r_byteValid <= 1'b1;
                        r_checksum  <= r_checksum ^ w_curByte;
                        r_state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (tx_done) begin
                        r_state <= SEND;
                        unique case (r_item)
                            HDR: begin
                                r_item <= DIMS;
                            end
                            DIMS: begin
                                r_item    <= ROW;
                                r_rowIdx  <= '0;
                                r_byteIdx <= '0;
                            end
                            ROW: begin
                                if (w_lastRowByte) begin
                                    r_byteIdx <= '0;
                                    if (w_lastRow) begin
                                        r_item <= CHK;
                                    end else begin
                                        r_rowIdx <= r_rowIdx + DIM_W'(1);
                                    end
                                end else begin
                                    r_byteIdx <= r_byteIdx + DIM_W'(1);
                                end
                            end
                            CHK: begin
                                r_frameDone <= 1'b1;
                                r_busy      <= 1'b0;
                                r_state     <= IDLE;
                            end
                        endcase
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
